beat_timer: RTL and testbench
=============================

Name: beat_timer

Overview:
- Consumer end of the beat strobe: counts incoming 1/32 s beat pulses down from a loaded duration.
- Emits a one-cycle done pulse when the duration expires.
- Sits between the beat generator and the note/sequence controller: the controller loads a note length in beats; this block reports when the note ends.
- Load/ready handshake on the input side; done pulse on the output side.

Parameters:
- DUR_W, 6, width of duration and remaining count in beats (max 2^DUR_W-1 beats).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- beat  input  1  one-cycle beat strobe from the beat generator.
- load_valid  input  1  controller presents a new duration.
- load_dur  input  DUR_W  duration in beats; sampled when load_valid & load_ready.
- abort  input  1  cancel the running timer without a done pulse.
- load_ready  output  1  high in IDLE and DONE states.
- busy  output  1  high in RUN state.
- done  output  1  one-cycle pulse when the duration expires.
- remaining  output  DUR_W  beats left; 0 when not running.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, remaining=0, done=0, busy=0, load_ready=1.
  - Reset overrides all other inputs in the same cycle, including mid-RUN; no done pulse is issued.
- States:
  - IDLE: load_ready=1, busy=0, done=0.
  - RUN: load_ready=0, busy=1.
  - DONE: single cycle; done=1, load_ready=1, busy=0.
- Transitions:
  - IDLE, accept with load_dur!=0 -> RUN, remaining=load_dur.
  - IDLE, accept with load_dur==0 -> DONE next cycle, remaining=0 (zero-length note still signals completion).
  - RUN, beat and remaining>1 -> stay RUN, remaining-=1.
  - RUN, beat and remaining==1 -> DONE, remaining=0.
  - RUN, abort -> IDLE, remaining=0, no done. Abort wins over a simultaneous beat.
  - DONE, accept -> same rules as IDLE (back-to-back notes, zero idle gap).
  - DONE, no accept -> IDLE.
  - abort in IDLE or DONE: no effect on state; a load accepted in the same cycle is discarded.
- Accept is defined as load_valid & load_ready & ~abort.
- load_valid while RUN is ignored, not queued; the controller must hold it until load_ready.
- A beat in the accept cycle is not counted. Counting starts on the first beat in a later cycle.
- Latency: done asserts the cycle after the Nth counted beat.
- Remaining decrements only in RUN; it never wraps below 0.
- All outputs are registered except load_ready and busy, which decode directly from the state register.

Optional Feature:
- Macro: BEAT_TIMER_PAUSE_EN.
- With the macro defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN, beats are ignored and remaining holds.
  - abort still works during pause.
  - pause has no effect in IDLE or DONE.
- Without the macro: no pause port; every beat in RUN is counted.

Decomposition:
- Shared package beat_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - DUR_W default constant.
  - Beat-rate constant shared with the beat generator (3125000 cycles per beat).
- Registers use the codebase's synchronous-reset flop (dffr), instantiated per register.
- Sub-module: beat_down_counter holds remaining. Inputs: load, load value, dec enable, clear. Outputs: count, count_is_one flag.
- The FSM stays in beat_timer.

Test Plan:
- Reset mid-RUN (load 5, two beats, then reset) -> next cycle state IDLE, remaining=0, load_ready=1, no done ever.
- Load 3, beats on cycles 4/10/20 -> remaining 3,2,1,0; done=1 exactly on cycle 21, busy low from cycle 21.
- Load 0 -> done pulse the cycle after accept, remaining stays 0, never busy.
- Load 2 with beat asserted in the accept cycle -> that beat is ignored; two further beats are required before done.
- Back-to-back: in the DONE cycle, load 1 -> RUN next cycle; next beat -> second done pulse; zero idle cycles between notes.
- Abort with simultaneous beat at remaining=1 -> IDLE, no done. With BEAT_TIMER_PAUSE_EN: load 2, pause=1 across 3 beats -> remaining holds at 2; release pause, 2 beats -> done.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared beat-timing definitions: state encoding, default duration width and
// the beat rate used by the beat generator.
package beat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } beat_state_e;

    localparam int unsigned DUR_W_DEF       = 6;
    localparam int unsigned CYCLES_PER_BEAT = 32'd3125000;

endpackage

// File: rtl/beat_down_counter.sv
// Remaining-beats counter: clear beats load beats decrement; never wraps below 0.
module beat_down_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         count_is_one
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // next count selection
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {W{1'b0}};
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    dffr #(.W(W), .RST_VAL({W{1'b0}})) u_count (
        .clk   (clk),
        .reset (reset),
        .d     (count_d),
        .q     (count_q)
    );

    assign count        = count_q;
    assign count_is_one = (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dffr.sv
// Generic W-bit flop with synchronous active-high reset to RST_VAL.
module dffr #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/beat_timer.sv
// Beat-driven note timer: loads a duration in beats, counts beats down and
// pulses done on expiry. Optional pause input enabled by BEAT_TIMER_PAUSE_EN.
module beat_timer
    import beat_pkg::*;
#(
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    input  logic             load_valid,
    input  logic [DUR_W-1:0] load_dur,
    input  logic             abort,
`ifdef BEAT_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             load_ready,
    output logic             busy,
    output logic             done,
    output logic [DUR_W-1:0] remaining
);

    logic [1:0]  state_bits;
    beat_state_e state_q;
    beat_state_e state_d;
    logic        done_d;
    logic        done_q;
    logic        accept_s;
    logic        beat_s;
    logic        cnt_load_s;
    logic        cnt_dec_s;
    logic        cnt_clear_s;
    logic        cnt_is_one_s;

    assign state_q    = beat_state_e'(state_bits);
    assign load_ready = (state_q == IDLE) || (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign accept_s   = load_valid & load_ready & ~abort;

`ifdef BEAT_TIMER_PAUSE_EN
    assign beat_s = beat & ~pause;
`else
    assign beat_s = beat;
`endif

    // next-state and counter control
    always_comb begin
        state_d     = state_q;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_clear_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (load_dur != {DUR_W{1'b0}}) begin
                        state_d    = RUN;
                        cnt_load_s = 1'b1;
                    end else begin
                        state_d     = DONE;
                        cnt_clear_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // abort takes priority over a beat in the same cycle
                if (abort) begin
                    state_d     = IDLE;
                    cnt_clear_s = 1'b1;
                end else if (beat_s) begin
                    cnt_dec_s = 1'b1;
                    if (cnt_is_one_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_clear_s = 1'b1;
            end
        endcase
    end

    assign done_d = (state_d == DONE);

    dffr #(.W(2), .RST_VAL(2'd0)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_bits)
    );

    dffr #(.W(1), .RST_VAL(1'b0)) u_done (
        .clk   (clk),
        .reset (reset),
        .d     (done_d),
        .q     (done_q)
    );

    beat_down_counter #(.W(DUR_W)) u_cnt (
        .clk          (clk),
        .reset        (reset),
        .load         (cnt_load_s),
        .load_val     (load_dur),
        .dec          (cnt_dec_s),
        .clear        (cnt_clear_s),
        .count        (remaining),
        .count_is_one (cnt_is_one_s)
    );

    assign done = done_q;

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer: directed scenarios plus random traffic
// against a behavioural note model. Pause checks need BEAT_TIMER_PAUSE_EN.
module tb_beat_timer;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          beat;
    logic          load_valid;
    logic [DW-1:0] load_dur;
    logic          abort;
    logic          pause;
    logic          load_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] remaining;

    int tests = 0;
    int fails = 0;

    // behavioural model: is a note running, beats left in it, done expected
    bit m_run;
    int m_left;
    bit m_done;

    always #5 clk = ~clk;

    beat_timer #(.DUR_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .beat       (beat),
        .load_valid (load_valid),
        .load_dur   (load_dur),
        .abort      (abort),
`ifdef BEAT_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .load_ready (load_ready),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit eff_beat;
`ifdef BEAT_TIMER_PAUSE_EN
        eff_beat = beat && !pause;
`else
        eff_beat = beat;
`endif
        m_done = 1'b0;
        if (reset) begin
            m_run  = 1'b0;
            m_left = 0;
        end else if (m_run) begin
            if (abort) begin
                m_run  = 1'b0;
                m_left = 0;
            end else if (eff_beat) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (load_valid && !abort) begin
            if (load_dur == 0) m_done = 1'b1;
            else begin
                m_run  = 1'b1;
                m_left = int'(load_dur);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic lv, input int ld,
                       input logic b, input logic ab, input logic p);
        reset      = r;
        load_valid = lv;
        load_dur   = DW'(ld);
        beat       = b;
        abort      = ab;
        pause      = p;
        @(posedge clk);
        model_step();
        #1;
        chk("load_ready", load_ready, !m_run);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("remaining", remaining, m_run ? m_left : 0);
    endtask

    initial begin
        int dones;
        m_run = 1'b0; m_left = 0; m_done = 1'b0;

        // reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_remaining", remaining, 0);

        // reset mid-RUN
        cyc(0, 1, 5, 0, 0, 0);
        chk("mid_rem5", remaining, 5);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("mid_rem3", remaining, 3);
        cyc(1, 0, 0, 1, 0, 0);
        chk("mid_rst_rem", remaining, 0);
        chk("mid_rst_ready", load_ready, 1);
        chk("mid_rst_done", done, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_rst_nodone", done, 0);

        // load 3, beats on cycles 4/10/20 after the accept cycle
        cyc(0, 1, 3, 0, 0, 0);
        chk("l3_rem", remaining, 3);
        for (int k = 1; k <= 21; k++) begin
            cyc(0, 0, 0, (k == 4 || k == 10 || k == 20), 0, 0);
            if (k == 19) chk("l3_pre_done", done, 0);
            if (k == 20) begin
                chk("l3_done", done, 1);
                chk("l3_busy", busy, 0);
                chk("l3_rem0", remaining, 0);
            end
            if (k == 21) chk("l3_done_once", done, 0);
        end

        // zero-length note
        cyc(0, 1, 0, 0, 0, 0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("z_done_off", done, 0);

        // beat in accept cycle ignored
        cyc(0, 1, 2, 1, 0, 0);
        chk("acc_beat_rem", remaining, 2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("acc_beat_nodone", done, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("acc_beat_done", done, 1);

        // back-to-back: load 1 in the DONE cycle
        cyc(0, 1, 1, 0, 0, 0);
        chk("b2b_busy", busy, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("b2b_done", done, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // abort wins over simultaneous beat at remaining=1
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", load_ready, 1);
        // abort in IDLE discards a same-cycle load
        cyc(0, 1, 4, 0, 1, 0);
        chk("abort_idle_busy", busy, 0);

`ifdef BEAT_TIMER_PAUSE_EN
        cyc(0, 1, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 1);
        chk("pause_hold", remaining, 2);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("pause_done", done, 1);
`endif

        // randomized traffic against the model
        dones = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) == 0));
            if (done) dones++;
        end
        chk("rand_saw_done", (dones > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
